line_bank_scheduler: RTL

LINE_BANK_SCHEDULER -- requirements
Module: line_bank_scheduler

---
 rtl/line_bank_scheduler_if.sv | 26 ++
 rtl/line_bank_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/line_bank_scheduler_if.sv
// Event/status bundle between the line timing logic and the three-bank line scheduler.
interface line_bank_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic             wr_line_start;
    logic             wr_line_done;
    logic             frame_start;
    logic             rd_line_start;
    logic [1:0]       wr_bank;
    logic             wr_active;
    logic [1:0]       rd_bank;
    logic             rd_valid;
    logic             rd_fresh;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] repeat_count;

    modport master (
        output wr_line_start, wr_line_done, frame_start, rd_line_start,
        input  wr_bank, wr_active, rd_bank, rd_valid, rd_fresh, drop_count, repeat_count
    );

    modport slave (
        input  wr_line_start, wr_line_done, frame_start, rd_line_start,
        output wr_bank, wr_active, rd_bank, rd_valid, rd_fresh, drop_count, repeat_count
    );
endinterface

// File: rtl/line_bank_scheduler.sv
// Triple-buffer line scheduler: assigns RAM banks to an analog line writer and an HDMI line
// reader, always handing the reader the newest complete line and counting drops/repeats.
module line_bank_scheduler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    line_bank_scheduler_if.slave  bus
);
    localparam int unsigned NB = 3;

    typedef enum logic [1:0] {FREE, FILLING, READY, READING} bank_st_e;

    bank_st_e         st_q   [NB];
    logic [1:0]       age_q  [NB];
    bank_st_e         nst    [NB];
    logic [1:0]       nage   [NB];

    logic [1:0]       wr_bank_q, rd_bank_q;
    logic             wr_active_q, rd_valid_q, rd_fresh_q;
    logic [CNT_W-1:0] drop_q, repeat_q;

    logic [1:0]       wr_bank_d, rd_bank_d;
    logic             wr_active_d, rd_valid_d, rd_fresh_d;
    logic [CNT_W-1:0] drop_d, repeat_d;

    logic [1:0]       wr_sel, rd_sel, best_age, drop_inc;
    logic             found, rd_take, rep_inc;
    logic [CNT_W:0]   drop_sum, repeat_sum;

    // State register
    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            for (int unsigned i = 0; i < NB; i++) begin
                st_q[i]  <= FREE;
                age_q[i] <= '0;
            end
            wr_bank_q   <= '0;
            wr_active_q <= 1'b0;
            rd_bank_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_fresh_q  <= 1'b0;
            drop_q      <= '0;
            repeat_q    <= '0;
        end else begin
            st_q        <= nst;
            age_q       <= nage;
            wr_bank_q   <= wr_bank_d;
            wr_active_q <= wr_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_valid_q  <= rd_valid_d;
            rd_fresh_q  <= rd_fresh_d;
            drop_q      <= drop_d;
            repeat_q    <= repeat_d;
        end
    end

    // Next bank states; events applied in order frame, done, write start, read start.
    // Age 0 marks the newest READY bank, larger ages are older.
    always_comb begin : next_state_comb
        nst      = st_q;
        nage     = age_q;
        wr_sel   = wr_bank_q;
        rd_sel   = rd_bank_q;
        rd_take  = 1'b0;
        rep_inc  = 1'b0;
        drop_inc = '0;
        found    = 1'b0;
        best_age = '0;

        if (bus.frame_start) begin
            for (int unsigned i = 0; i < NB; i++)
                if (nst[i] == FILLING || nst[i] == READY) nst[i] = FREE;
        end else if (bus.wr_line_done) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (nst[i] == FILLING) begin
                    for (int unsigned j = 0; j < NB; j++)
                        if (nst[j] == READY && nage[j] != 2'd3) nage[j] = nage[j] + 2'd1;
                    nst[i]  = READY;
                    nage[i] = '0;
                end
            end
        end

        if (bus.wr_line_start) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (nst[i] == FILLING) begin
                    nst[i]   = FREE;
                    drop_inc = drop_inc + 2'd1;
                end
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (!found && nst[i] == FREE) begin
                    found  = 1'b1;
                    wr_sel = 2'(i);
                end
            end
            if (!found) begin
                // No FREE bank: reclaim the oldest READY line
                for (int unsigned i = 0; i < NB; i++) begin
                    if (nst[i] == READY && (!found || nage[i] > best_age)) begin
                        found    = 1'b1;
                        wr_sel   = 2'(i);
                        best_age = nage[i];
                    end
                end
                drop_inc = drop_inc + 2'd1;
            end
            nst[wr_sel] = FILLING;
        end

        if (bus.rd_line_start) begin
            found    = 1'b0;
            best_age = '0;
            for (int unsigned i = 0; i < NB; i++) begin
                if (nst[i] == READY && (!found || nage[i] < best_age)) begin
                    found    = 1'b1;
                    rd_sel   = 2'(i);
                    best_age = nage[i];
                end
            end
            if (found) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (nst[i] == READING) begin
                        nst[i] = FREE;
                    end else if (nst[i] == READY && 2'(i) != rd_sel) begin
                        nst[i]   = FREE;
                        drop_inc = drop_inc + 2'd1;
                    end
                end
                nst[rd_sel] = READING;
                rd_take     = 1'b1;
            end else begin
                rep_inc = rd_valid_q;
            end
        end
    end

    // Next output values
    always_comb begin : next_output_comb
        wr_active_d = 1'b0;
        rd_valid_d  = 1'b0;
        wr_bank_d   = wr_sel;
        rd_bank_d   = rd_sel;
        rd_fresh_d  = rd_take;
        for (int unsigned i = 0; i < NB; i++) begin
            if (nst[i] == FILLING) wr_active_d = 1'b1;
            if (nst[i] == READING) rd_valid_d  = 1'b1;
        end
        drop_sum   = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
        repeat_sum = {1'b0, repeat_q} + (CNT_W+1)'(rep_inc);
        drop_d     = drop_sum[CNT_W]   ? '1 : drop_sum[CNT_W-1:0];
        repeat_d   = repeat_sum[CNT_W] ? '1 : repeat_sum[CNT_W-1:0];
    end

    assign bus.wr_bank      = wr_bank_q;
    assign bus.wr_active    = wr_active_q;
    assign bus.rd_bank      = rd_bank_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_fresh     = rd_fresh_q;
    assign bus.drop_count   = drop_q;
    assign bus.repeat_count = repeat_q;
endmodule
